// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester bus plus UART TX FIFO write port shared through uart_tx_arbiter.
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 4
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*LEN_W-1:0] req_len;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ*8-1:0]     req_data;
    logic [NUM_REQ-1:0]       req_ready;
    logic [NUM_REQ-1:0]       grant;
    logic                     uart_can_receive;
    logic                     uart_wr_en;
    logic [7:0]               uart_d_in;
    logic                     busy;
    logic                     done;
    logic                     err;
    modport master (
        output req, req_len, req_valid, req_data, uart_can_receive,
        input  req_ready, grant, uart_wr_en, uart_d_in, busy, done, err
    );
    modport slave (
        input  req, req_len, req_valid, req_data, uart_can_receive,
        output req_ready, grant, uart_wr_en, uart_d_in, busy, done, err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin burst arbiter sharing one UART TX FIFO write port,
// with an idle-timeout abort for stalled owners.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 64
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [LEN_W:0] CNT_LAST = 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    typedef enum logic {IDLE, XFER} state_t;
    state_t state;
    logic [IW-1:0] own, last, sel;
    logic [NUM_REQ-1:0] grant;
    logic [LEN_W:0] cnt;
    logic [TW-1:0] tcnt;
    logic [LEN_W-1:0] len_sel;
    logic [7:0] dat;
    logic busy, done, err, vld, xfer, fin;
    // Second pass overrides the first, so owners above last win before wrapping.
    always_comb begin
        sel = '0;
        len_sel = '0;
        vld = 1'b0;
        dat = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (bus.req[i] && i <= int'(last)) sel = IW'(i);
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (bus.req[i] && i > int'(last)) sel = IW'(i);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IW'(i) == sel) len_sel = bus.req_len[i*LEN_W +: LEN_W];
            if (IW'(i) == own) begin
                vld = bus.req_valid[i];
                dat = bus.req_data[i*8 +: 8];
            end
        end
    end
    assign xfer = busy && vld && bus.uart_can_receive;
    assign fin = (xfer && cnt == CNT_LAST) || (!vld && tcnt == TO_LAST);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            own <= '0;
            last <= IW'(NUM_REQ - 1);
            grant <= '0;
            cnt <= '0;
            tcnt <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            err <= 1'b0;
        end else begin
            done <= 1'b0;
            err <= 1'b0;
            if (state == IDLE) begin
                if (|bus.req) begin
                    state <= XFER;
                    own <= sel;
                    grant <= NUM_REQ'(1) << sel;
                    cnt <= {1'b0, len_sel} + 1'b1;
                    tcnt <= '0;
                    busy <= 1'b1;
                end
            end else begin
                if (xfer) cnt <= cnt - 1'b1;
                tcnt <= xfer ? '0 : (vld ? tcnt : tcnt + 1'b1);
                if (fin) begin
                    done <= xfer;
                    err <= !vld;
                    state <= IDLE;
                    last <= own;
                    grant <= '0;
                    busy <= 1'b0;
                end
            end
        end
    end
    assign bus.grant = grant;
    assign bus.busy = busy;
    assign bus.done = done;
    assign bus.err = err;
    assign bus.req_ready = grant & {NUM_REQ{bus.uart_can_receive}};
    assign bus.uart_wr_en = xfer;
    assign bus.uart_d_in = busy ? dat : 8'h00;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: table-driven per-cycle vectors plus directed multi-cycle
// sequences for backpressure, timeout, isolation and async reset.
module tb_uart_tx_arbiter;
    localparam int NR = 4;
    localparam int LW = 4;
    localparam int TO = 16;
    typedef struct {
        logic [3:0]  req;
        logic [15:0] len;
        logic [3:0]  valid;
        logic [31:0] data;
        logic        can;
        logic [3:0]  grant;
        logic [3:0]  ready;
        logic        wr;
        logic [7:0]  d;
        logic        busy;
        logic        done;
    } vec_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0, failures = 0;
    int cyc = 0, last_wr_cyc = 0, err_cyc = 0;
    int done_cnt = 0, err_cnt = 0, ovf = 0, iso_bad = 0, bp_bad = 0;
    int n0, d0, e0;
    bit iso_on = 0, stalled = 0, got_err = 0;
    logic [7:0] wr_q[$];
    vec_t tv[$];
    uart_tx_arbiter_if #(.NUM_REQ(NR), .LEN_W(LW)) bus ();
    uart_tx_arbiter #(.NUM_REQ(NR), .LEN_W(LW), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.uart_wr_en) begin
                wr_q.push_back(bus.uart_d_in);
                last_wr_cyc = cyc;
            end
            if (bus.uart_wr_en && !bus.uart_can_receive) ovf++;
            if (bus.done) done_cnt++;
            if (bus.err) begin
                err_cnt++;
                err_cyc = cyc;
            end
            if (iso_on && (bus.uart_d_in == 8'hFF || bus.req_ready[1])) iso_bad++;
        end
    end
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask
    task automatic clear_inputs();
        bus.req = '0;
        bus.req_len = '0;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.uart_can_receive = 1'b1;
    endtask
    task automatic reset_dut();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask
    task automatic chk_bytes(input string nm, input int base, input logic [7:0] first, input int n);
        chk({nm, "_count"}, wr_q.size() - base, n);
        for (int k = 0; k < n; k++)
            if (base + k < wr_q.size()) chk($sformatf("%s_byte%0d", nm, k), wr_q[base+k], first + 8'(k));
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
    initial begin
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grant", bus.grant, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_wr_en", bus.uart_wr_en, 0);
        chk("rst_d_in", bus.uart_d_in, 0);
        chk("rst_ready", bus.req_ready, 0);
        rst = 1'b0;
        // Round robin: every len=0, one byte per grant, one bubble between grants.
        tv.push_back('{4'hF, 16'h0000, 4'hF, 32'h44332211, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0});
        tv.push_back('{4'hF, 16'h0000, 4'hF, 32'h44332211, 1'b1, 4'h1, 4'h1, 1'b1, 8'h11, 1'b1, 1'b0});
        tv.push_back('{4'hF, 16'h0000, 4'hF, 32'h44332211, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1});
        tv.push_back('{4'hF, 16'h0000, 4'hF, 32'h44332211, 1'b1, 4'h2, 4'h2, 1'b1, 8'h22, 1'b1, 1'b0});
        tv.push_back('{4'hF, 16'h0000, 4'hF, 32'h44332211, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1});
        tv.push_back('{4'hF, 16'h0000, 4'hF, 32'h44332211, 1'b1, 4'h4, 4'h4, 1'b1, 8'h33, 1'b1, 1'b0});
        tv.push_back('{4'hF, 16'h0000, 4'hF, 32'h44332211, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1});
        tv.push_back('{4'hF, 16'h0000, 4'hF, 32'h44332211, 1'b1, 4'h8, 4'h8, 1'b1, 8'h44, 1'b1, 1'b0});
        tv.push_back('{4'hF, 16'h0000, 4'hF, 32'h44332211, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1});
        tv.push_back('{4'h0, 16'h0000, 4'hF, 32'h44332211, 1'b1, 4'h1, 4'h1, 1'b1, 8'h11, 1'b1, 1'b0});
        tv.push_back('{4'h0, 16'h0000, 4'hF, 32'h44332211, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1});
        tv.push_back('{4'h0, 16'h0000, 4'hF, 32'h44332211, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0});
        // Single burst on requester 1, len=2, one backpressure cycle, req dropped mid-burst.
        tv.push_back('{4'h2, 16'h0020, 4'h2, 32'h0000A100, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0});
        tv.push_back('{4'h2, 16'h0020, 4'h2, 32'h0000A100, 1'b1, 4'h2, 4'h2, 1'b1, 8'hA1, 1'b1, 1'b0});
        tv.push_back('{4'h2, 16'h0020, 4'h2, 32'h0000A200, 1'b0, 4'h2, 4'h0, 1'b0, 8'hA2, 1'b1, 1'b0});
        tv.push_back('{4'h2, 16'h0020, 4'h2, 32'h0000A200, 1'b1, 4'h2, 4'h2, 1'b1, 8'hA2, 1'b1, 1'b0});
        tv.push_back('{4'h0, 16'h0020, 4'h2, 32'h0000A300, 1'b1, 4'h2, 4'h2, 1'b1, 8'hA3, 1'b1, 1'b0});
        tv.push_back('{4'h0, 16'h0020, 4'h2, 32'h0000A300, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1});
        tv.push_back('{4'h0, 16'h0020, 4'h2, 32'h0000A300, 1'b1, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        foreach (tv[i]) begin
            bus.req = tv[i].req;
            bus.req_len = tv[i].len;
            bus.req_valid = tv[i].valid;
            bus.req_data = tv[i].data;
            bus.uart_can_receive = tv[i].can;
            #1;
            chk($sformatf("v%0d_grant", i), bus.grant, tv[i].grant);
            chk($sformatf("v%0d_ready", i), bus.req_ready, tv[i].ready);
            chk($sformatf("v%0d_wr_en", i), bus.uart_wr_en, tv[i].wr);
            chk($sformatf("v%0d_d_in", i), bus.uart_d_in, tv[i].d);
            chk($sformatf("v%0d_busy", i), bus.busy, tv[i].busy);
            chk($sformatf("v%0d_done", i), bus.done, tv[i].done);
            chk($sformatf("v%0d_err", i), bus.err, 0);
            @(posedge clk);
            #1;
        end
        // Backpressure: requester 2, 4 bytes, 100-cycle stall after byte 2.
        clear_inputs();
        n0 = wr_q.size();
        d0 = done_cnt;
        e0 = err_cnt;
        bus.req = 4'b0100;
        bus.req_len = 16'h0300;
        bus.req_valid = 4'b0100;
        bus.req_data = 32'h00B00000;
        for (int c = 0; c < 40 && done_cnt == d0; c++) begin
            @(posedge clk);
            #1;
            if (bus.busy) bus.req = '0;
            bus.req_data = {8'h00, 8'hB0 + 8'(wr_q.size() - n0), 16'h0000};
            if (!stalled && wr_q.size() - n0 == 2) begin
                stalled = 1;
                bus.uart_can_receive = 1'b0;
                for (int s = 0; s < 100; s++) begin
                    #1;
                    if (bus.uart_wr_en || bus.err) bp_bad++;
                    @(posedge clk);
                    #1;
                end
                bus.uart_can_receive = 1'b1;
            end
        end
        chk("bp_stalled", stalled, 1);
        chk("bp_stall_clean", bp_bad, 0);
        chk("bp_no_err", err_cnt - e0, 0);
        chk("bp_done", done_cnt - d0, 1);
        chk_bytes("bp", n0, 8'hB0, 4);
        // Timeout: requester 0, len=5, valid drops after 2 bytes.
        clear_inputs();
        n0 = wr_q.size();
        e0 = err_cnt;
        bus.req = 4'b0001;
        bus.req_len = 16'h0005;
        bus.req_valid = 4'b0001;
        bus.req_data = 32'h000000D0;
        for (int c = 0; c < 20 && wr_q.size() - n0 < 2; c++) begin
            @(posedge clk);
            #1;
            bus.req_data = {24'h0, 8'hD0 + 8'(wr_q.size() - n0)};
        end
        bus.req_valid = '0;
        bus.req = 4'b0011;
        for (int c = 0; c < TO + 10; c++) begin
            @(posedge clk);
            #2;
            if (bus.err) begin
                got_err = 1;
                break;
            end
        end
        chk("to_err_seen", got_err, 1);
        chk("to_grant_at_err", bus.grant, 0);
        chk("to_busy_at_err", bus.busy, 0);
        @(negedge clk);
        #1;
        chk("to_latency", err_cyc - last_wr_cyc, TO + 1);
        chk("to_err_once", err_cnt - e0, 1);
        chk_bytes("to", n0, 8'hD0, 2);
        @(posedge clk);
        #1;
        chk("to_next_grant", bus.grant, 4'b0010);
        chk("to_err_cleared", bus.err, 0);
        // Isolation: requester 3 drops req; requester 1 shows 0xFF on valid data.
        reset_dut();
        n0 = wr_q.size();
        d0 = done_cnt;
        iso_on = 1;
        bus.req = 4'b1000;
        bus.req_len = 16'h3000;
        bus.req_valid = 4'b1010;
        bus.req_data = 32'hC000FF00;
        for (int c = 0; c < 20 && done_cnt == d0; c++) begin
            @(posedge clk);
            #1;
            bus.req_data[31:24] = 8'hC0 + 8'(wr_q.size() - n0);
            if (wr_q.size() - n0 >= 1) bus.req = '0;
        end
        iso_on = 0;
        chk("iso_no_leak", iso_bad, 0);
        chk("iso_done", done_cnt - d0, 1);
        chk_bytes("iso", n0, 8'hC0, 4);
        // Async reset after the first byte of a len=7 burst.
        clear_inputs();
        n0 = wr_q.size();
        bus.req = 4'b0001;
        bus.req_len = 16'h0007;
        bus.req_valid = 4'b0001;
        bus.req_data = 32'h000000E0;
        for (int c = 0; c < 10 && wr_q.size() - n0 < 1; c++) begin
            @(posedge clk);
            #1;
        end
        chk("ar_busy_before", bus.busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_grant", bus.grant, 0);
        chk("ar_busy", bus.busy, 0);
        chk("ar_wr_en", bus.uart_wr_en, 0);
        chk("ar_ready", bus.req_ready, 0);
        chk("ar_d_in", bus.uart_d_in, 0);
        chk("ar_done", bus.done, 0);
        chk("ar_err", bus.err, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("ar_regrant", bus.grant, 4'b0001);
        chk("ar_rebusy", bus.busy, 1);
        chk("no_wr_without_room", ovf, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin, packet-level arbiter that shares the single UART TX path among NUM_REQ requesters.
- Sits in front of the TX FIFO write port (wr_en, d_in, tx_can_receive_signal) of the UART top.
- Grants one requester at a time for a whole burst of len+1 bytes, then moves the grant on.
- Aborts and reports an error when a granted requester stalls too long.

Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- LEN_W, 4: width of each length field; burst size is len+1, range 1..2^LEN_W bytes.
- TIMEOUT, 64: consecutive idle cycles (granted requester not valid) before the burst is aborted; ≥2.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester burst request, level.
- req_len  input  NUM_REQ*LEN_W  packed burst lengths; slice i belongs to requester i; value n means n+1 bytes.
- req_valid  input  NUM_REQ  per-requester byte valid.
- req_data  input  NUM_REQ*8  packed byte data; slice i belongs to requester i.
- req_ready  output  NUM_REQ  per-requester byte accept.
- grant  output  NUM_REQ  one-hot current owner; all zero when idle.
- uart_can_receive  input  1  TX FIFO not full (tx_can_receive_signal).
- uart_wr_en  output  1  TX FIFO write strobe.
- uart_d_in  output  8  TX FIFO write data.
- busy  output  1  high while a burst is owned.
- done  output  1  one-cycle pulse when the last byte of a burst is written.
- err  output  1  one-cycle pulse on a timeout abort.

Behaviour:
- Reset values: grant=0, busy=0, done=0, err=0, uart_wr_en=0, uart_d_in=0, req_ready=0.
- Reset state: FSM=IDLE, byte counter=0, timeout counter=0, last-owner pointer=NUM_REQ-1 (requester 0 wins first).
- FSM has two states: IDLE and XFER.
- IDLE arbitration:
  - If any req bit is set, pick the first set bit searching upward from last_owner+1, wrapping modulo NUM_REQ.
  - Register grant (one-hot), load cnt = req_len slice + 1, clear timeout counter, go to XFER.
  - Grant appears the cycle after req is first sampled high.
- IDLE with no req: stay in IDLE; all outputs stay inactive.
- req is sampled only in IDLE. Deasserting req during XFER is ignored; the burst continues.
- XFER handshake:
  - req_ready[g] = uart_can_receive (combinational) for the owner g; all other req_ready bits are 0.
  - A transfer occurs when req_valid[g] && req_ready[g].
  - uart_wr_en = transfer and uart_d_in = req_data slice g, both combinational in the same cycle.
  - uart_wr_en is never asserted while uart_can_receive=0, so the FIFO cannot overflow.
  - Non-granted requesters never reach uart_wr_en.
- Counting and completion:
  - Each transfer decrements cnt.
  - A transfer with cnt==1 completes the burst: done pulses the next cycle, last_owner←g, grant←0, FSM→IDLE.
  - New arbitration can win at the earliest one cycle after that, i.e. one idle bubble per burst.
- Timeout:
  - The counter increments each XFER cycle with req_valid[g]=0 and clears on any transfer.
  - Cycles with valid=1 but uart_can_receive=0 (FIFO backpressure) hold the counter; they never time out.
  - When the counter reaches TIMEOUT: err pulses the next cycle, last_owner←g, grant←0, FSM→IDLE, bytes already written stay in the FIFO.
- busy equals (FSM==XFER), registered together with grant.
- Width rules:
  - cnt is LEN_W+1 bits, so len=all-ones gives 2^LEN_W without overflow.
  - The timeout counter is $clog2(TIMEOUT+1) bits.
- Asynchronous reset mid-burst: returns immediately to the reset values above; the partial burst is not resumed.

Test Plan:
- Single burst: req[1]=1, len=2, valid held high, can_receive=1.
  - grant=0010 one cycle after req.
  - Exactly 3 uart_wr_en pulses carrying requester 1's bytes (e.g. 0xA1, 0xA2, 0xA3).
  - done pulses once, then grant=0.
- Round-robin fairness: req=1111, every len=0, valid always high.
  - Grant order 0,1,2,3,0,… with exactly 1 byte written per grant.
  - One bubble cycle between consecutive grants.
- Backpressure: requester 2 len=3; can_receive low for 100 cycles midway.
  - No wr_en while can_receive=0 and no err despite 100 > TIMEOUT.
  - All 4 bytes delivered in order.
- Timeout: requester 0 granted with len=5; valid drops after byte 2 and stays low.
  - err pulses exactly TIMEOUT+1 cycles after the last transfer.
  - grant=0, and the next grant goes to requester 1 when req=0011.
- Request drop and isolation: requester 3 drops req mid-burst while requester 1 drives valid with 0xFF.
  - The burst completes fully.
  - 0xFF never appears on uart_d_in; req_ready[1] stays 0.
- Async reset mid-burst: rst pulsed after byte 1 of a len=7 burst.
  - All outputs return to 0 immediately.
  - After release, req=0001 is granted to requester 0.
